// File: rtl/ow_temp_sequencer_if.sv
// Control and engine-command bundle for ow_temp_sequencer.
// master = the sequencer, slave = control logic plus the 1-wire byte engine.
interface ow_temp_sequencer_if;
   logic        start;
   logic        busy;
   logic        done;
   logic [15:0] temp;
   logic        err_presence;
   logic        crc_err;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_data;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic        rsp_presence;

   modport master (
      input  start, cmd_ready, rsp_valid, rsp_data, rsp_presence,
      output busy, done, temp, err_presence, crc_err, cmd_valid, cmd_op, cmd_data
   );

   modport slave (
      output start, cmd_ready, rsp_valid, rsp_data, rsp_presence,
      input  busy, done, temp, err_presence, crc_err, cmd_valid, cmd_op, cmd_data
   );
endinterface

// File: rtl/ow_temp_sequencer.sv
// One DS18B20-class temperature read per start pulse, driving a byte-level 1-wire engine.
// Define OW_CRC_CHECK_EN to read the full scratchpad and check its Dallas CRC-8.
module ow_temp_sequencer #(
   parameter int unsigned CONV_WAIT = 32'd75_000_000,
   parameter logic [7:0]  CMD_SKIP  = 8'hCC,
   parameter logic [7:0]  CMD_CONV  = 8'h44,
   parameter logic [7:0]  CMD_READ  = 8'hBE
) (
   input logic                 clk,
   input logic                 reset,
   ow_temp_sequencer_if.master bus
);

   localparam logic [1:0] OpReset = 2'b00;
   localparam logic [1:0] OpWrite = 2'b01;
   localparam logic [1:0] OpRead  = 2'b10;
`ifdef OW_CRC_CHECK_EN
   localparam logic [3:0] LastByte = 4'd8;
`else
   localparam logic [3:0] LastByte = 4'd1;
`endif

   typedef enum logic [3:0] {
      StIdle, StRst1, StSkip1, StConv, StWait, StRst2, StSkip2, StRdCmd, StRead, StTerm, StFin
   } state_e;

   state_e      state;
   logic        busy;
   logic        done;
   logic        cmd_valid;
   logic        pending;
   logic        err_presence;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_data;
   logic [15:0] temp;
   logic [7:0]  temp_lo;
   logic [7:0]  temp_hi;
   logic [31:0] wait_cnt;
   logic [3:0]  byte_idx;
   logic        rsp_hit;

   // Responses only count while an accepted command is outstanding.
   assign rsp_hit = pending & bus.rsp_valid;

`ifdef OW_CRC_CHECK_EN
   logic [7:0] crc;
   logic [7:0] crc_next;
   logic       crc_err;

   always_comb begin
      crc_next = crc;
      for (int i = 0; i < 8; i++) begin
         if (crc_next[0] ^ bus.rsp_data[i]) crc_next = (crc_next >> 1) ^ 8'h8C;
         else                               crc_next = crc_next >> 1;
      end
   end

   assign bus.crc_err = crc_err;
`else
   assign bus.crc_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= StIdle;
         busy         <= 1'b0;
         done         <= 1'b0;
         cmd_valid    <= 1'b0;
         pending      <= 1'b0;
         err_presence <= 1'b0;
         cmd_op       <= OpReset;
         cmd_data     <= 8'h00;
         temp         <= 16'h0000;
         temp_lo      <= 8'h00;
         temp_hi      <= 8'h00;
         wait_cnt     <= 32'd0;
         byte_idx     <= 4'd0;
`ifdef OW_CRC_CHECK_EN
         crc          <= 8'h00;
         crc_err      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (cmd_valid && bus.cmd_ready) begin
            cmd_valid <= 1'b0;
            pending   <= 1'b1;
         end
         case (state)
            StIdle: begin
               if (bus.start) begin
                  state        <= StRst1;
                  busy         <= 1'b1;
                  err_presence <= 1'b0;
`ifdef OW_CRC_CHECK_EN
                  crc_err      <= 1'b0;
`endif
                  cmd_valid    <= 1'b1;
                  cmd_op       <= OpReset;
                  cmd_data     <= 8'h00;
               end
            end
            StRst1, StRst2: begin
               if (rsp_hit) begin
                  pending <= 1'b0;
                  if (bus.rsp_presence) begin
                     state     <= (state == StRst1) ? StSkip1 : StSkip2;
                     cmd_valid <= 1'b1;
                     cmd_op    <= OpWrite;
                     cmd_data  <= CMD_SKIP;
                  end else begin
                     err_presence <= 1'b1;
                     state        <= StFin;
                     done         <= 1'b1;
                     busy         <= 1'b0;
                  end
               end
            end
            StSkip1: begin
               if (rsp_hit) begin
                  pending   <= 1'b0;
                  state     <= StConv;
                  cmd_valid <= 1'b1;
                  cmd_op    <= OpWrite;
                  cmd_data  <= CMD_CONV;
               end
            end
            StConv: begin
               if (rsp_hit) begin
                  pending  <= 1'b0;
                  state    <= StWait;
                  wait_cnt <= 32'd0;
               end
            end
            StWait: begin
               if (wait_cnt == CONV_WAIT - 32'd1) begin
                  state     <= StRst2;
                  cmd_valid <= 1'b1;
                  cmd_op    <= OpReset;
                  cmd_data  <= 8'h00;
               end else begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
            end
            StSkip2: begin
               if (rsp_hit) begin
                  pending   <= 1'b0;
                  state     <= StRdCmd;
                  cmd_valid <= 1'b1;
                  cmd_op    <= OpWrite;
                  cmd_data  <= CMD_READ;
               end
            end
            StRdCmd: begin
               if (rsp_hit) begin
                  pending   <= 1'b0;
                  state     <= StRead;
                  byte_idx  <= 4'd0;
`ifdef OW_CRC_CHECK_EN
                  crc       <= 8'h00;
`endif
                  cmd_valid <= 1'b1;
                  cmd_op    <= OpRead;
                  cmd_data  <= 8'h00;
               end
            end
            StRead: begin
               if (rsp_hit) begin
                  pending <= 1'b0;
                  if (byte_idx == 4'd0) temp_lo <= bus.rsp_data;
                  if (byte_idx == 4'd1) temp_hi <= bus.rsp_data;
`ifdef OW_CRC_CHECK_EN
                  crc <= crc_next;
`endif
                  if (byte_idx == LastByte) begin
`ifdef OW_CRC_CHECK_EN
                     state <= StFin;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     // A zero residue over all nine bytes means the stored CRC matched.
                     if (crc_next == 8'h00) temp <= {temp_hi, temp_lo};
                     else                   crc_err <= 1'b1;
`else
                     state     <= StTerm;
                     cmd_valid <= 1'b1;
                     cmd_op    <= OpReset;
                     cmd_data  <= 8'h00;
`endif
                  end else begin
                     byte_idx  <= byte_idx + 4'd1;
                     cmd_valid <= 1'b1;
                     cmd_op    <= OpRead;
                     cmd_data  <= 8'h00;
                  end
               end
            end
            StTerm: begin
               if (rsp_hit) begin
                  pending <= 1'b0;
                  state   <= StFin;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  temp    <= {temp_hi, temp_lo};
               end
            end
            StFin: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

   assign bus.busy         = busy;
   assign bus.done         = done;
   assign bus.temp         = temp;
   assign bus.err_presence = err_presence;
   assign bus.cmd_valid    = cmd_valid;
   assign bus.cmd_op       = cmd_op;
   assign bus.cmd_data     = cmd_data;

endmodule
